periph_rx_fifo: RTL

- Peripheral-side receiver that sits directly downstream of the CPU handshake FSM.
- Consumes 4-bit words over the send/ack four-phase handshake, buffers them in a small FIFO, and presents them to the peripheral core on a valid/ready interface.
- Applies back-pressure to the CPU by withholding ack while the FIFO is full.

---
 rtl/periph_rx_fifo_if.sv | 28 ++
 rtl/periph_rx_fifo.sv | 102 ++++++++++
 2 files changed

// File: rtl/periph_rx_fifo_if.sv
// Handshake bundle between the CPU-side sender, the receive FIFO and the peripheral core.
// The FIFO takes the slave view; the CPU/consumer side takes the master view.
interface periph_rx_fifo_if;
    logic       send;
    logic [3:0] data;
    logic       ack;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output send,
        output data,
        output out_ready,
        input  ack,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  send,
        input  data,
        input  out_ready,
        output ack,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/periph_rx_fifo.sv
// Peripheral receiver: accepts one 4-bit word per send/ack four-phase handshake into a small FIFO
// and presents it on a valid/ready port; ack is withheld while the FIFO is full.
module periph_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    periph_rx_fifo_if.slave          bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         rx_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef enum logic {IDLE, ACKED} state_t;

    state_t           state_reg;
    logic             ack_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic [CNT_W-1:0] rx_count_reg;
    logic [3:0]       mem [DEPTH];

    logic accept;
    logic pop;

    // Full check uses the level before the edge, so a same-edge pop never frees room for a push.
    assign accept = (state_reg == IDLE) && bus.send && (level_reg != FULL_LEVEL);
    assign pop    = (level_reg != '0) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ack_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg <= ACKED;
                        ack_reg   <= 1'b1;
                    end else begin
                        ack_reg   <= 1'b0;
                    end
                end
                ACKED: begin
                    if (!bus.send) begin
                        state_reg <= IDLE;
                        ack_reg   <= 1'b0;
                    end else begin
                        ack_reg   <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ack_reg   <= 1'b0;
                end
            endcase
        end
    end

    // Storage is written only on accept, so garbage on data outside a handshake never lands in it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 4'h0;
            end
        end else if (accept) begin
            mem[wr_ptr_reg] <= bus.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            rx_count_reg <= '0;
        end else begin
            if (accept) begin
                wr_ptr_reg   <= wr_ptr_reg + AW'(1);
                rx_count_reg <= rx_count_reg + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({accept, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign bus.ack       = ack_reg;
    assign bus.out_data  = mem[rd_ptr_reg];
    assign bus.out_valid = (level_reg != '0);
    assign level         = level_reg;
    assign rx_count      = rx_count_reg;
endmodule
